addsub_pipe: RTL and testbench

Parametrised, pipelined adder/subtractor: the next generation of the single-cycle `adder` primitive. It adds or subtracts two operands of independent width, with the operation selected per sample. The carry chain is split across a configurable number of register stages, so wide operands close timing at high clock rates. It sits in the primitives library as the arithmetic building block for accumulators, DDS phase logic and FIR post-adders, and carries a valid flag and a global stall.

---
 rtl/addsub_pipe.sv | 152 +++++++++++++++
 tb/tb_addsub_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/subtract of two independently sized operands, result MAXW+1 bits.
// Latency: exactly PIPE_STAGES enabled cycles from valid_i to valid_o; one sample per enabled cycle.
// Backpressure: none beyond en_i; en_i=0 freezes every stage (data and valid), nothing lost or duplicated.
//
// Ports: clk, rst_n (async, active-low); en_i stall; valid_i/sub_i/data1_i/data2_i sample in;
//        data_o (MAXW+1 bits), valid_o, overflow_o out.
// Build option: define ADDSUB_SAT_EN to clamp the result to the MAXW-bit range and flag it on
//               overflow_o; otherwise data_o is the full-width result and overflow_o is tied low.
module addsub_pipe #(
  parameter int DATA_WIDTH_1 = 16,
  parameter int DATA_WIDTH_2 = 16,
  parameter int PIPE_STAGES  = 2,
  parameter int SIGNED       = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic valid_i,
  input  logic sub_i,
  input  logic [DATA_WIDTH_1-1:0] data1_i,
  input  logic [DATA_WIDTH_2-1:0] data2_i,
  output logic [((DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2):0] data_o,
  output logic valid_o,
  output logic overflow_o
);

  localparam int MAXW      = (DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2;
  localparam int OUT_WIDTH = MAXW + 1;
  localparam int SEG_W     = (OUT_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4 || PIPE_STAGES > OUT_WIDTH ||
      DATA_WIDTH_1 < 2 || DATA_WIDTH_1 > 64 ||
      DATA_WIDTH_2 < 2 || DATA_WIDTH_2 > 64) begin : g_bad_cfg
    $error("addsub_pipe: unsupported parameter combination");
  end

  // Per-stage state. 's' holds the finished low segments plus the carry out of the
  // previous segment, parked at the first bit of the current segment, so the next
  // stage's addition picks the carry up without a separate carry register.
  typedef struct packed {
    logic                 v;
`ifdef ADDSUB_SAT_EN
    logic                 sub;
`endif
    logic [OUT_WIDTH-1:0] a;
    logic [OUT_WIDTH-1:0] b;
    logic [OUT_WIDTH-1:0] s;
  } stage_t;

  logic                 sign1;
  logic                 sign2;
  logic [OUT_WIDTH-1:0] a_ext;
  logic [OUT_WIDTH-1:0] b_ext;

  assign sign1 = (SIGNED != 0) ? data1_i[DATA_WIDTH_1-1] : 1'b0;
  assign sign2 = (SIGNED != 0) ? data2_i[DATA_WIDTH_2-1] : 1'b0;
  assign a_ext = {{(OUT_WIDTH-DATA_WIDTH_1){sign1}}, data1_i};
  assign b_ext = {{(OUT_WIDTH-DATA_WIDTH_2){sign2}}, data2_i};

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    // Segment k covers bits [LO, HI); trailing segments may be empty when the
    // remainder runs out, in which case the stage is a plain delay.
    localparam int LO = (k * SEG_W < OUT_WIDTH) ? k * SEG_W : OUT_WIDTH;
    localparam int HI = ((k + 1) * SEG_W < OUT_WIDTH) ? (k + 1) * SEG_W : OUT_WIDTH;
    localparam logic [OUT_WIDTH-1:0] SEG_MASK = OUT_WIDTH'((66'd1 << HI) - (66'd1 << LO));

    stage_t               cur;
    logic [OUT_WIDTH-1:0] t;

    if (k == 0) begin : g_src
      // Subtract is A + ~B + 1: B is inverted here and the +1 rides in s[0].
      always_comb begin
        cur     = '0;
        cur.v   = valid_i;
`ifdef ADDSUB_SAT_EN
        cur.sub = sub_i;
`endif
        cur.a   = a_ext;
        cur.b   = b_ext ^ {OUT_WIDTH{sub_i}};
        cur.s   = OUT_WIDTH'(sub_i);
      end
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cur <= '0;
        end else if (en_i) begin
          cur   <= g_stage[k-1].cur;
          cur.s <= g_stage[k-1].t;
        end
      end
    end

    // Carry out of this segment lands at bit HI of t; a carry out of the top bit
    // is dropped, giving the result mod 2^OUT_WIDTH.
    assign t = cur.s + (cur.a & SEG_MASK) + (cur.b & SEG_MASK);
  end

  logic [OUT_WIDTH-1:0] res;
  logic                 res_v;

  assign res   = g_stage[PIPE_STAGES-1].t;
  assign res_v = g_stage[PIPE_STAGES-1].cur.v;

`ifdef ADDSUB_SAT_EN
  logic                 res_sub;
  logic [OUT_WIDTH-1:0] sat_val;
  logic                 sat_ov;

  assign res_sub = g_stage[PIPE_STAGES-1].cur.sub;

  always_comb begin
    sat_val = res;
    sat_ov  = 1'b0;
    if (SIGNED != 0) begin
      // Exact signed result leaves the MAXW-bit range when the top two bits differ.
      if (res[MAXW] != res[MAXW-1]) begin
        sat_ov  = 1'b1;
        sat_val = res[MAXW] ? {2'b11, {(MAXW-1){1'b0}}} : {2'b00, {(MAXW-1){1'b1}}};
      end
    end else if (res[MAXW]) begin
      // Unsigned: top bit is the add carry or the subtract borrow.
      sat_ov  = 1'b1;
      sat_val = res_sub ? '0 : {1'b0, {MAXW{1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (en_i) begin
      data_o     <= sat_val;
      valid_o    <= res_v;
      overflow_o <= sat_ov & res_v;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (en_i) begin
      data_o  <= res;
      valid_o <= res_v;
    end
  end

  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed checks of addsub_pipe in three configurations.
// Instance a: defaults (16/16, 2 stages, unsigned); s: signed 8/16, 3 stages;
// n: unsigned 8/8, 4 stages (9-bit result, last segment empty).
module tb_addsub_pipe;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic en;
  logic valid;
  logic sub;

  logic [15:0] a_d1, a_d2;
  logic [16:0] a_do;
  logic        a_vo, a_ov;

  logic [7:0]  s_d1;
  logic [15:0] s_d2;
  logic [16:0] s_do;
  logic        s_vo, s_ov;

  logic [7:0]  n_d1, n_d2;
  logic [8:0]  n_do;
  logic        n_vo, n_ov;

  int n_chk = 0;
  int n_err = 0;

  addsub_pipe #(.DATA_WIDTH_1(16), .DATA_WIDTH_2(16), .PIPE_STAGES(2), .SIGNED(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .valid_i(valid), .sub_i(sub),
    .data1_i(a_d1), .data2_i(a_d2), .data_o(a_do), .valid_o(a_vo), .overflow_o(a_ov));

  addsub_pipe #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(16), .PIPE_STAGES(3), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .en_i(en), .valid_i(valid), .sub_i(sub),
    .data1_i(s_d1), .data2_i(s_d2), .data_o(s_do), .valid_o(s_vo), .overflow_o(s_ov));

  addsub_pipe #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(8), .PIPE_STAGES(4), .SIGNED(0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .en_i(en), .valid_i(valid), .sub_i(sub),
    .data1_i(n_d1), .data2_i(n_d2), .data_o(n_do), .valid_o(n_vo), .overflow_o(n_ov));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int sel, input logic [15:0] a, input logic [15:0] b);
    case (sel)
      0:       begin a_d1 = a;      a_d2 = b;      end
      1:       begin s_d1 = a[7:0]; s_d2 = b;      end
      default: begin n_d1 = a[7:0]; n_d2 = b[7:0]; end
    endcase
  endtask

  function automatic logic [16:0] get_d(input int sel);
    case (sel)
      0:       return a_do;
      1:       return s_do;
      default: return {8'h00, n_do};
    endcase
  endfunction

  function automatic logic get_v(input int sel);
    case (sel)
      0:       return a_vo;
      1:       return s_vo;
      default: return n_vo;
    endcase
  endfunction

  function automatic logic get_ov(input int sel);
    case (sel)
      0:       return a_ov;
      1:       return s_ov;
      default: return n_ov;
    endcase
  endfunction

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 2 : (sel == 1) ? 3 : 4;
  endfunction

  task automatic flush();
    valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // One sample: valid_o must stay low until exactly lat enabled edges, then pulse once.
  task automatic single(input int sel, input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [16:0] exp_d, input logic exp_ov);
    int lat;
    lat = lat_of(sel);
    flush();
    put(sel, a, b);
    sub   = s;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_early"}, get_v(sel), 1'b0);
      @(negedge clk);
    end
    chk({tag, "_v"}, get_v(sel), 1'b1);
    chk({tag, "_d"}, get_d(sel), exp_d);
    chk({tag, "_ov"}, get_ov(sel), exp_ov);
    @(negedge clk);
    chk({tag, "_pulse"}, get_v(sel), 1'b0);
  endtask

  // Two back-to-back samples: results on consecutive cycles, then valid_o low.
  task automatic pair(input int sel, input string tag,
                      input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                      input logic [16:0] e0, input logic o0,
                      input logic [15:0] a1, input logic [15:0] b1, input logic s1,
                      input logic [16:0] e1, input logic o1);
    int lat;
    lat = lat_of(sel);
    flush();
    put(sel, a0, b0);
    sub   = s0;
    valid = 1'b1;
    @(negedge clk);
    put(sel, a1, b1);
    sub = s1;
    @(negedge clk);
    valid = 1'b0;
    for (int e = 2; e < lat; e++) @(negedge clk);
    chk({tag, "_v0"}, get_v(sel), 1'b1);
    chk({tag, "_d0"}, get_d(sel), e0);
    chk({tag, "_ov0"}, get_ov(sel), o0);
    @(negedge clk);
    chk({tag, "_v1"}, get_v(sel), 1'b1);
    chk({tag, "_d1"}, get_d(sel), e1);
    chk({tag, "_ov1"}, get_ov(sel), o1);
    @(negedge clk);
    chk({tag, "_end"}, get_v(sel), 1'b0);
  endtask

  // Stall stream: step i drives en_t[i] and sample sidx[i] (valid for i <= 6);
  // exp_v/exp_d are the instance-a outputs after the edge of that step.
  logic [15:0] st_a   [4] = '{16'h0001, 16'h1000, 16'hFFF0, 16'h8000};
  logic [15:0] st_b   [4] = '{16'h0002, 16'h0001, 16'h000F, 16'h8000};
  logic        st_s   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        en_t   [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int          sidx   [9] = '{0, 1, 2, 2, 2, 2, 3, 3, 3};
  logic        exp_v  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [16:0] exp_d  [9] = '{17'h0, 17'h00003, 17'h00003, 17'h00003, 17'h00003,
                              17'h00FFF, 17'h0FFFF, 17'h00000, 17'h0};

  initial begin
    int n_deliv;
    rst_n = 1'b0;
    en    = 1'b1;
    valid = 1'b0;
    sub   = 1'b0;
    a_d1 = '0; a_d2 = '0; s_d1 = '0; s_d2 = '0; n_d1 = '0; n_d2 = '0;

    repeat (2) @(negedge clk);
    chk("rst_a_d", a_do, 17'h0);
    chk("rst_a_v", a_vo, 1'b0);
    chk("rst_a_ov", a_ov, 1'b0);
    chk("rst_s_d", s_do, 17'h0);
    chk("rst_s_v", s_vo, 1'b0);
    chk("rst_n_d", n_do, 9'h0);
    chk("rst_n_v", n_vo, 1'b0);
    rst_n = 1'b1;

    // Default configuration.
    single(0, "add", 16'h52F2, 16'h2234, 1'b0, 17'h07526, 1'b0);
    single(0, "sub_borrow", 16'h2234, 16'h52F2, 1'b1, SAT ? 17'h00000 : 17'h1CF42, SAT);
    pair(0, "seg_carry", 16'h01FF, 16'h0001, 1'b0, 17'h00200, 1'b0,
                         16'hFFFF, 16'hFFFF, 1'b0, SAT ? 17'h0FFFF : 17'h1FFFE, SAT);
    pair(0, "alt_sub", 16'h0005, 16'h0009, 1'b1, SAT ? 17'h00000 : 17'h1FFFC, SAT,
                       16'h0005, 16'h0009, 1'b0, 17'h0000E, 1'b0);

    // Signed, mismatched widths.
    pair(1, "s_mix", 16'h0080, 16'h7FFF, 1'b0, 17'h07F7F, 1'b0,
                     16'h007F, 16'h8000, 1'b1, SAT ? 17'h07FFF : 17'h0807F, SAT);
    pair(1, "s_neg", 16'h00FF, 16'h0001, 1'b0, 17'h00000, 1'b0,
                     16'h0080, 16'h7FFF, 1'b1, SAT ? 17'h18000 : 17'h17F81, SAT);

    // Narrow operands, four stages.
    single(2, "n_max", 16'h00FF, 16'h0001, 1'b0, SAT ? 17'h000FF : 17'h00100, SAT);
    pair(2, "n_seg", 16'h0007, 16'h0001, 1'b0, 17'h00008, 1'b0,
                     16'h0000, 16'h0001, 1'b1, SAT ? 17'h00000 : 17'h001FF, SAT);

    // Stall mid-stream on the default instance.
    flush();
    n_deliv = 0;
    for (int i = 0; i < 9; i++) begin
      en    = en_t[i];
      valid = (i <= 6);
      put(0, st_a[sidx[i]], st_b[sidx[i]]);
      sub = st_s[sidx[i]];
      @(negedge clk);
      chk($sformatf("stall_v%0d", i), a_vo, exp_v[i]);
      if (exp_v[i]) chk($sformatf("stall_d%0d", i), a_do, exp_d[i]);
      if (en_t[i] && a_vo) n_deliv++;
    end
    chk("stall_count", n_deliv, 4);
    en    = 1'b1;
    valid = 1'b0;

    // Reset with two samples in flight.
    flush();
    put(0, 16'h0000, 16'h0001);
    sub   = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    put(0, 16'h0003, 16'h0001);
    sub = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    chk("rst_pre_v", a_vo, 1'b1);
    chk("rst_pre_d", a_do, SAT ? 17'h00000 : 17'h1FFFF);
    chk("rst_pre_ov", a_ov, SAT);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_d", a_do, 17'h0);
    chk("rst_mid_v", a_vo, 1'b0);
    chk("rst_mid_ov", a_ov, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst_stale_a%0d", i), a_vo, 1'b0);
      chk($sformatf("rst_stale_s%0d", i), s_vo, 1'b0);
      chk($sformatf("rst_stale_n%0d", i), n_vo, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
